// File: rtl/tf_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tf_buffer_ctrl
//   Sequencer in front of the twiddle-factor buffer.  Commands arrive one at a
//   time over a valid/ready port.  A load streams words from the s_* port into
//   one limb region of the buffer.  A read streams a limb region out to the
//   NTT/DFT datapath, with tf_valid/tf_last aligned to the buffer read latency.
//   The word address is limb*WORDS_PER_LIMB + ((base+cnt) mod WORDS_PER_LIMB),
//   so a region wraps inside its own limb.  The same address is driven to
//   every bank.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (accepted only in IDLE)
//   cmd_op          0 = load, 1 = read
//   cmd_limb        target limb
//   cmd_base        starting word offset within the limb
//   cmd_len         word count, 0..256
//   s_valid/ready   load data handshake (ready only while loading)
//   s_data          load data, one word per bank
//   tf_valid/last   read data valid / final word of a read command
//   tf_data         read data (buf_dout passed straight through)
//   done, err       one-cycle completion pulse, err qualifies done
//   buf_addr        buffer address, replicated into every bank slice
//   buf_we          buffer write enable
//   buf_din         buffer write data (s_data passed straight through)
//   buf_dout        buffer read data
// -----------------------------------------------------------------------------
module tf_buffer_ctrl #(
   parameter int ADDR_WIDTH     = 13,
   parameter int DATA_WIDTH     = 216,
   parameter int NBANK          = 128,
   parameter int LIMBS          = 32,
   parameter int WORDS_PER_LIMB = 256,
   parameter int RD_LAT         = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_op,
   input  logic [4:0]                    cmd_limb,
   input  logic [7:0]                    cmd_base,
   input  logic [8:0]                    cmd_len,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [NBANK*DATA_WIDTH-1:0]   s_data,
   output logic                          tf_valid,
   output logic                          tf_last,
   output logic [NBANK*DATA_WIDTH-1:0]   tf_data,
   output logic                          done,
   output logic                          err,
   output logic [NBANK*ADDR_WIDTH-1:0]   buf_addr,
   output logic                          buf_we,
   output logic [NBANK*DATA_WIDTH-1:0]   buf_din,
   input  logic [NBANK*DATA_WIDTH-1:0]   buf_dout
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]              state;
   logic [4:0]              limb_q;
   logic [7:0]              base_q;
   logic [8:0]              len_q;
   logic [8:0]              cnt;
   logic                    err_q;
   logic [RD_LAT-1:0]       pipe_v;
   logic [RD_LAT-1:0]       pipe_l;

   logic                    last_cnt;
   logic                    beat;
   logic                    issue;
   logic [8:0]              off_sum;
   logic [8:0]              word_off;
   logic [ADDR_WIDTH-1:0]   addr_calc;
   logic [ADDR_WIDTH-1:0]   addr_out;

   // Address generation.  Masking the offset sum with WORDS_PER_LIMB-1 keeps a
   // region inside its limb; the limb term is a plain shift because
   // WORDS_PER_LIMB is a power of two.
   always_comb begin
      off_sum   = {1'b0, base_q} + cnt;
      word_off  = off_sum & 9'(WORDS_PER_LIMB - 1);
      addr_calc = ADDR_WIDTH'(limb_q) * ADDR_WIDTH'(WORDS_PER_LIMB)
                + ADDR_WIDTH'(word_off);
      last_cnt  = (cnt == len_q - 9'd1);
      issue     = (state == ST_READ);
      beat      = s_valid && s_ready;
   end

   // Command sequencer.  A command is latched on acceptance in IDLE; rejected
   // and empty commands go straight to DONE so they still produce a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         limb_q <= '0;
         base_q <= '0;
         len_q  <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  limb_q <= cmd_limb;
                  base_q <= cmd_base;
                  len_q  <= cmd_len;
                  cnt    <= '0;
                  err_q  <= (int'(cmd_limb) >= LIMBS);
                  if ((int'(cmd_limb) >= LIMBS) || (cmd_len == 9'd0))
                     state <= ST_DONE;
                  else if (cmd_op)
                     state <= ST_READ;
                  else
                     state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  cnt <= cnt + 9'd1;
                  if (last_cnt)
                     state <= ST_DONE;
               end
            end
            ST_READ: begin
               cnt <= cnt + 9'd1;
               if (last_cnt)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pipe_v == '0)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read alignment: each issued address pushes a valid (and its last flag)
   // into a RD_LAT-deep shift register so tf_valid lines up with buf_dout.
   // Reset flushes it, which drops any words still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         pipe_l <= '0;
      end else begin
         pipe_v[0] <= issue;
         pipe_l[0] <= issue && last_cnt;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
      end
   end

   // Output decode.  Everything is forced low while rst is high so the block
   // is quiet during reset regardless of the state register.
   always_comb begin
      cmd_ready = !rst && (state == ST_IDLE);
      s_ready   = !rst && (state == ST_LOAD);
      buf_we    = s_valid && s_ready;
      addr_out  = (!rst && ((state == ST_LOAD) || (state == ST_READ)))
                ? addr_calc : '0;
      buf_addr  = {NBANK{addr_out}};
      buf_din   = s_data;
      tf_data   = buf_dout;
      tf_valid  = !rst && pipe_v[RD_LAT-1];
      tf_last   = !rst && pipe_l[RD_LAT-1];
      done      = !rst && (state == ST_DONE);
      err       = done && err_q;
   end

endmodule

// File: tb/tb_tf_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tf_buffer_ctrl
//   Scoreboard bench for tf_buffer_ctrl.  The stimulus process issues directed
//   commands and pushes the expected writes, read words and done pulses, each
//   tagged with the cycle it must appear in.  A monitor pops and compares
//   whenever the DUT shows buf_we, tf_valid or done.  A behavioural buffer
//   with a two-cycle read latency sits on the buf_* port.  A second, small
//   instance with LIMBS=24 exercises the out-of-range limb rejection, which
//   cannot be reached with a 5-bit limb field and 32 limbs.
// -----------------------------------------------------------------------------
module tb_tf_buffer_ctrl;

   localparam int TAW    = 13;
   localparam int TDW    = 216;
   localparam int TNB    = 4;
   localparam int TW     = TNB * TDW;
   localparam int TRDLAT = 2;
   localparam int WPL    = 256;

   typedef struct { int cyc; logic [TAW-1:0] addr; logic [TW-1:0] data; } wr_t;
   typedef struct { int cyc; logic [TW-1:0] data; logic last; } tf_t;
   typedef struct { int cyc; logic err; } dn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   logic             cmd_valid = 1'b0, cmd_op = 1'b0;
   logic [4:0]       cmd_limb = '0;
   logic [7:0]       cmd_base = '0;
   logic [8:0]       cmd_len = '0;
   logic             s_valid = 1'b0;
   logic [TW-1:0]    s_data = '0;
   logic             cmd_ready, s_ready, tf_valid, tf_last, done, err, buf_we;
   logic [TW-1:0]    tf_data, buf_din;
   logic [TW-1:0]    rd1 = '0, rd2 = '0;
   logic [TNB*TAW-1:0] buf_addr;

   logic             c2_valid = 1'b0, c2_op = 1'b0;
   logic [4:0]       c2_limb = '0;
   logic [8:0]       c2_len = '0;
   logic             s2_valid = 1'b0;
   logic [7:0]       s2_data = 8'h3C;
   logic [7:0]       buf2_dout = 8'h5A;
   logic             c2_ready, s2_ready, tf2_valid, tf2_last, done2, err2, buf2_we;
   logic [7:0]       tf2_data, buf2_din;
   logic [TAW-1:0]   buf2_addr;

   logic [TW-1:0]    mem    [int];
   logic [TW-1:0]    shadow [int];
   wr_t wrQ[$];
   tf_t tfQ[$];
   dn_t dnQ[$];
   dn_t d2Q[$];
   wr_t eW;
   tf_t eT;
   dn_t eD, eD2;
   bit  sliceOk;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   tf_buffer_ctrl #(.ADDR_WIDTH(TAW), .DATA_WIDTH(TDW), .NBANK(TNB), .LIMBS(32),
                    .WORDS_PER_LIMB(WPL), .RD_LAT(TRDLAT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_limb(cmd_limb), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .tf_valid(tf_valid), .tf_last(tf_last), .tf_data(tf_data),
      .done(done), .err(err), .buf_addr(buf_addr), .buf_we(buf_we),
      .buf_din(buf_din), .buf_dout(rd2)
   );

   tf_buffer_ctrl #(.ADDR_WIDTH(TAW), .DATA_WIDTH(8), .NBANK(1), .LIMBS(24),
                    .WORDS_PER_LIMB(WPL), .RD_LAT(TRDLAT)) dut2 (
      .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_op(c2_op), .cmd_limb(c2_limb), .cmd_base(8'd7), .cmd_len(c2_len),
      .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
      .tf_valid(tf2_valid), .tf_last(tf2_last), .tf_data(tf2_data),
      .done(done2), .err(err2), .buf_addr(buf2_addr), .buf_we(buf2_we),
      .buf_din(buf2_din), .buf_dout(buf2_dout)
   );

   // Word contents unique per address, bank and tag, filling every bit.
   function automatic logic [TW-1:0] patWord(input int a, input int tag);
      logic [TW-1:0] w;
      logic [47:0]   unit;
      logic [239:0]  rep;
      w = '0;
      for (int b = 0; b < TNB; b++) begin
         unit = {tag[15:0], b[15:0], a[15:0]};
         rep  = {5{unit}};
         w[b*TDW +: TDW] = rep[TDW-1:0];
      end
      return w;
   endfunction

   function automatic logic [TW-1:0] memRead(input int a);
      return mem.exists(a) ? mem[a] : patWord(a, 'hFFFF);
   endfunction

   function automatic logic [TW-1:0] expWord(input int a);
      return shadow.exists(a) ? shadow[a] : patWord(a, 'hFFFF);
   endfunction

   function automatic int addrOf(input int limb, input int base, input int i);
      return limb * WPL + ((base + i) % WPL);
   endfunction

   // Behavioural buffer: registered read with two cycles address-to-data.
   always @(posedge clk) begin
      rd1 <= memRead(int'(buf_addr[TAW-1:0]));
      rd2 <= rd1;
      if (buf_we)
         mem[int'(buf_addr[TAW-1:0])] = buf_din;
   end

   task automatic checkOutput(input string name, input bit ok, input string detail);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL %s: %s", name, detail);
      end
   endtask

   // Main monitor: every buf_we, tf_valid and done must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (buf_we) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpected_write", 1'b0,
                  $sformatf("buf_we=1 at cycle %0d addr %0d, required no write", cyc, buf_addr[TAW-1:0]));
            end else begin
               eW = wrQ.pop_front();
               sliceOk = 1'b1;
               for (int b = 0; b < TNB; b++)
                  if (buf_addr[b*TAW +: TAW] !== eW.addr) sliceOk = 1'b0;
               checkOutput("write", (cyc == eW.cyc) && sliceOk && (buf_din === eW.data),
                  $sformatf("got cycle %0d addr %0d slices_equal %0b din %h, required cycle %0d addr %0d din %h",
                            cyc, buf_addr[TAW-1:0], sliceOk, buf_din[63:0], eW.cyc, eW.addr, eW.data[63:0]));
            end
         end
         if (tf_valid) begin
            if (tfQ.size() == 0) begin
               checkOutput("unexpected_tf", 1'b0,
                  $sformatf("tf_valid=1 at cycle %0d, required 0", cyc));
            end else begin
               eT = tfQ.pop_front();
               checkOutput("tf_word", (cyc == eT.cyc) && (tf_data === eT.data) && (tf_last === eT.last),
                  $sformatf("got cycle %0d last %0b data %h, required cycle %0d last %0b data %h",
                            cyc, tf_last, tf_data[63:0], eT.cyc, eT.last, eT.data[63:0]));
            end
         end
         if (done) begin
            if (dnQ.size() == 0) begin
               checkOutput("unexpected_done", 1'b0,
                  $sformatf("done=1 at cycle %0d, required 0", cyc));
            end else begin
               eD = dnQ.pop_front();
               checkOutput("done", (cyc == eD.cyc) && (err === eD.err),
                  $sformatf("got cycle %0d err %0b, required cycle %0d err %0b", cyc, err, eD.cyc, eD.err));
            end
         end
      end
   end

   // Second-instance monitor: only done pulses are expected there.
   always @(negedge clk) begin
      if (!rst) begin
         if (buf2_we || tf2_valid || tf2_last || s2_ready || (buf2_addr != '0))
            checkOutput("dut2_activity", 1'b0,
               $sformatf("we %0b tf_valid %0b tf_last %0b s_ready %0b addr %0d at cycle %0d, required all 0",
                         buf2_we, tf2_valid, tf2_last, s2_ready, buf2_addr, cyc));
         if (done2) begin
            if (d2Q.size() == 0) begin
               checkOutput("dut2_unexpected_done", 1'b0, $sformatf("done=1 at cycle %0d, required 0", cyc));
            end else begin
               eD2 = d2Q.pop_front();
               checkOutput("dut2_done",
                  (cyc == eD2.cyc) && (err2 === eD2.err) && (tf2_data === 8'h5A) && (buf2_din === 8'h3C),
                  $sformatf("got cycle %0d err %0b tf_data %h din %h, required cycle %0d err %0b tf_data 5a din 3c",
                            cyc, err2, tf2_data, buf2_din, eD2.cyc, eD2.err));
            end
         end
      end
   end

   task automatic finishRun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   // Present a command and return #1 after the accepting edge.
   task automatic applyStimulus(input logic op, input int limb, input int base, input int len);
      bit accepted = 1'b0;
      cmd_op    = op;
      cmd_limb  = 5'(limb);
      cmd_base  = 8'(base);
      cmd_len   = 9'(len);
      cmd_valid = 1'b1;
      for (int n = 0; n < 20 && !accepted; n++) begin
         @(negedge clk);
         if (cmd_ready) accepted = 1'b1;
      end
      if (!accepted) begin
         checkOutput("cmd_accept", 1'b0, "cmd_ready stayed 0 for 20 cycles, required 1");
         finishRun();
         $fatal(1, "[TB] command never accepted");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int n = 0; n < 3000; n++) begin
         if (wrQ.size() == 0 && tfQ.size() == 0 && dnQ.size() == 0 && d2Q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("drain", wrQ.size() == 0 && tfQ.size() == 0 && dnQ.size() == 0 && d2Q.size() == 0,
         $sformatf("pending wr %0d tf %0d done %0d done2 %0d, required all 0",
                   wrQ.size(), tfQ.size(), dnQ.size(), d2Q.size()));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Load: mask bit j gives s_valid for the j-th cycle after acceptance.
   task automatic loadLimb(input int limb, input int base, input int len,
                           input logic [31:0] mask, input int tag);
      int beats = 0;
      int j = 0;
      int a;
      applyStimulus(1'b0, limb, base, len);
      while (beats < len) begin
         s_valid = (j < 32) ? mask[j] : 1'b1;
         a = addrOf(limb, base, beats);
         s_data = patWord(a, tag + j);
         if (s_valid) begin
            wrQ.push_back('{cyc, TAW'(a), s_data});
            shadow[a] = s_data;
            beats++;
         end
         @(posedge clk);
         #1;
         j++;
      end
      s_valid = 1'b0;
      dnQ.push_back('{cyc, 1'b0});
      waitDrain();
   endtask

   // Read: s_valid is held high throughout and must be ignored.
   task automatic readLimb(input int limb, input int base, input int len);
      int k;
      s_valid = 1'b1;
      s_data  = patWord(0, 'h77);
      applyStimulus(1'b1, limb, base, len);
      k = cyc - 1;
      for (int i = 0; i < len; i++)
         tfQ.push_back('{k + 1 + i + TRDLAT, expWord(addrOf(limb, base, i)), i == len - 1});
      dnQ.push_back('{k + len + TRDLAT + 2, 1'b0});
      waitDrain();
      s_valid = 1'b0;
   endtask

   task automatic cmdDut2(input logic op, input int limb, input int len, input logic expErr);
      bit accepted = 1'b0;
      c2_op = op;
      c2_limb = 5'(limb);
      c2_len = 9'(len);
      c2_valid = 1'b1;
      for (int n = 0; n < 20 && !accepted; n++) begin
         @(negedge clk);
         if (c2_ready) accepted = 1'b1;
      end
      checkOutput("dut2_accept", accepted, $sformatf("accepted %0b, required 1", accepted));
      if (accepted) d2Q.push_back('{cyc + 1, expErr});
      @(posedge clk);
      #1;
      c2_valid = 1'b0;
      waitDrain();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs",
         ({cmd_ready, s_ready, tf_valid, tf_last, done, err, buf_we} === 7'b0) && (buf_addr === '0)
            && (c2_ready === 1'b0),
         $sformatf("ready %0b s_ready %0b tf_valid %0b tf_last %0b done %0b err %0b we %0b addr %0d, required all 0",
                   cmd_ready, s_ready, tf_valid, tf_last, done, err, buf_we, buf_addr[TAW-1:0]));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", cmd_ready === 1'b1, $sformatf("cmd_ready %0b, required 1", cmd_ready));
      @(posedge clk);
      #1;

      loadLimb(3, 0, 4, 32'hFFFF_FFFF, 'h100);
      loadLimb(3, 4, 4, 32'h0000_002D, 'h200);
      loadLimb(31, 254, 4, 32'hFFFF_FFFF, 'h300);
      readLimb(31, 254, 4);
      readLimb(3, 0, 8);

      // Zero-length command: done with err=0 the cycle after acceptance.
      s_valid = 1'b1;
      applyStimulus(1'b0, 5, 0, 0);
      dnQ.push_back('{cyc, 1'b0});
      waitDrain();
      s_valid = 1'b0;

      readLimb(3, 10, 256);

      // Reset after two read issues: nothing more may come out.
      applyStimulus(1'b1, 3, 0, 8);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("tf_after_midreset", (tf_valid === 1'b0) && (done === 1'b0),
         $sformatf("tf_valid %0b done %0b, required 0 0", tf_valid, done));
      checkOutput("ready_after_midreset", cmd_ready === 1'b1, $sformatf("cmd_ready %0b, required 1", cmd_ready));
      repeat (8) begin
         @(posedge clk);
         #1;
      end

      readLimb(31, 254, 4);
      loadLimb(0, 250, 8, 32'hFFFF_FFF5, 'h400);
      readLimb(0, 250, 8);

      s2_valid = 1'b1;
      cmdDut2(1'b0, 24, 5, 1'b1);
      cmdDut2(1'b1, 31, 3, 1'b1);
      cmdDut2(1'b1, 23, 0, 1'b0);
      s2_valid = 1'b0;

      checkOutput("queues_empty", wrQ.size() == 0 && tfQ.size() == 0 && dnQ.size() == 0 && d2Q.size() == 0,
         $sformatf("pending wr %0d tf %0d done %0d done2 %0d, required 0",
                   wrQ.size(), tfQ.size(), dnQ.size(), d2Q.size()));
      finishRun();
      $finish;
   end

endmodule
